// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: control-bundle field
// indices, register-index type and the hard-wired zero register.
package id_ex_stage_pkg;

    localparam int CTRL_W_DEF    = 16;
    localparam int CTRL_LOAD_BIT = 0;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

    // A write to x0 never produces a value, so it never matches a reader.
    function automatic logic idx_match(reg_idx_t a, reg_idx_t b);
        return (a != ZERO_REG) && (a == b);
    endfunction

endpackage

// File: rtl/id_ex_stage_operand_bypass.sv
// Single-operand source select: register-file data, writeback data when the
// writeback port targets the same source, or zero for x0.
module operand_bypass
    import id_ex_stage_pkg::*;
#(
    parameter bit BYPASS_ON = 1'b0
) (
    input  logic [4:0]  i_rs,
    input  logic [31:0] i_rd_data,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_op
);

    always_comb begin
        o_op = i_rd_data;
        if (i_rs == ZERO_REG) begin
            o_op = '0;
        end else if (BYPASS_ON && i_we && idx_match(i_wa, i_rs)) begin
            o_op = i_wd;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control
// and bubble counting. Define WB_BYPASS_EN to forward the writeback port.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int LOAD_BIT = CTRL_LOAD_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic [31:0]       RD1,
    input  logic [31:0]       RD2,
    input  logic              WE3,
    input  logic [4:0]        A3,
    input  logic [31:0]       WD3,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [31:0]       ex_op1,
    output logic [31:0]       ex_op2,
    output logic              hazard,
    output logic [15:0]       bubble_cnt
);

`ifdef WB_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    // Valid-only pipeline: ex_valid qualifies every EX field; the only
    // backpressure is stall, and hazard asks upstream to hold ID one cycle.
    logic              r_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_imm;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [31:0]       r_op1;
    logic [31:0]       r_op2;
    logic [15:0]       r_bubble_cnt;

    logic              w_hazard;
    logic [31:0]       w_op1;
    logic [31:0]       w_op2;

    assign w_hazard = r_valid && r_ctrl[LOAD_BIT] && (r_rd != ZERO_REG) && id_valid
                      && ((r_rd == id_rs1) || (r_rd == id_rs2));

    operand_bypass #(.BYPASS_ON(BYPASS_ON)) u_byp_op1 (
        .i_rs      (id_rs1),
        .i_rd_data (RD1),
        .i_we      (WE3),
        .i_wa      (A3),
        .i_wd      (WD3),
        .o_op      (w_op1)
    );

    operand_bypass #(.BYPASS_ON(BYPASS_ON)) u_byp_op2 (
        .i_rs      (id_rs2),
        .i_rd_data (RD2),
        .i_we      (WE3),
        .i_wa      (A3),
        .i_wd      (WD3),
        .o_op      (w_op2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_ctrl       <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (stall) begin
            // A held instruction must not miss a writeback that lands while it waits.
            if (BYPASS_ON && WE3 && idx_match(A3, r_rs1)) r_op1 <= WD3;
            if (BYPASS_ON && WE3 && idx_match(A3, r_rs2)) r_op2 <= WD3;
        end else if (w_hazard) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end else begin
            r_valid <= id_valid;
            r_pc    <= id_pc;
            r_imm   <= id_imm;
            r_ctrl  <= id_ctrl;
            r_rs1   <= id_rs1;
            r_rs2   <= id_rs2;
            r_rd    <= id_rd;
            r_op1   <= w_op1;
            r_op2   <= w_op2;
        end
    end

    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_imm     = r_imm;
    assign ex_ctrl    = r_ctrl;
    assign ex_rs1     = r_rs1;
    assign ex_rs2     = r_rs2;
    assign ex_rd      = r_rd;
    assign ex_op1     = r_op1;
    assign ex_op2     = r_op2;
    assign hazard     = w_hazard;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations are tagged with the cycle in
// which they must be observed and checked by an independent monitor.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic        hazard;
  logic [15:0] bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .RD1(RD1), .RD2(RD2), .WE3(WE3), .A3(A3), .WD3(WD3),
    .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .hazard(hazard), .bubble_cnt(bubble_cnt)
  );

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // mask bits: 0 valid,1 pc,2 imm,3 ctrl,4 rs1,5 rs2,6 rd,7 op1,8 op2,9 hazard,10 bubble
  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_REGS = 11'h5FF;
  localparam logic [10:0] M_HAZ  = 11'h200;
  localparam logic [10:0] M_BUB  = 11'h609;

  typedef struct packed {
    logic [31:0] cyc;
    logic [10:0] mask;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        hazard;
    logic [15:0] bubble;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   drive_done = 1'b0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [15:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2);
    id_valid = v; id_pc = pc; id_imm = imm; id_ctrl = ctrl;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; RD1 = d1; RD2 = d2;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    WE3 = we; A3 = a; WD3 = d;
  endtask

  task automatic push(input int c, input logic [10:0] m, input logic v, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [15:0] ctrl, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] op1,
                      input logic [31:0] op2, input logic hz, input logic [15:0] bub);
    exp_t e;
    e.cyc = c; e.mask = m; e.valid = v; e.pc = pc; e.imm = imm; e.ctrl = ctrl;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op1 = op1; e.op2 = op2; e.hazard = hz; e.bubble = bub;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard / monitor ----------------
  function automatic logic [31:0] act_field(int i);
    case (i)
      0: return {31'd0, ex_valid};
      1: return ex_pc;
      2: return ex_imm;
      3: return {16'd0, ex_ctrl};
      4: return {27'd0, ex_rs1};
      5: return {27'd0, ex_rs2};
      6: return {27'd0, ex_rd};
      7: return ex_op1;
      8: return ex_op2;
      9: return {31'd0, hazard};
      default: return {16'd0, bubble_cnt};
    endcase
  endfunction

  function automatic logic [31:0] exp_field(exp_t e, int i);
    case (i)
      0: return {31'd0, e.valid};
      1: return e.pc;
      2: return e.imm;
      3: return {16'd0, e.ctrl};
      4: return {27'd0, e.rs1};
      5: return {27'd0, e.rs2};
      6: return {27'd0, e.rd};
      7: return e.op1;
      8: return e.op2;
      9: return {31'd0, e.hazard};
      default: return {16'd0, e.bubble};
    endcase
  endfunction

  function automatic string fname(int i);
    case (i)
      0: return "ex_valid";
      1: return "ex_pc";
      2: return "ex_imm";
      3: return "ex_ctrl";
      4: return "ex_rs1";
      5: return "ex_rs2";
      6: return "ex_rd";
      7: return "ex_op1";
      8: return "ex_op2";
      9: return "hazard";
      default: return "bubble_cnt";
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (int'(e.cyc) < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_expect cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else begin
        for (int i = 0; i < 11; i++) begin
          if (e.mask[i]) begin
            checks++;
            if (act_field(i) !== exp_field(e, i)) begin
              errors++;
              $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                       fname(i), cyc, act_field(i), exp_field(e, i));
            end
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 16'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick(); tick();
    push(cyc, M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);

    // normal capture, first edge after reset release; x0 source reads as 0
    rst = 1'b1;
    set_id(1'b1, 32'h100, 32'h4, 16'h0004, 5'd3, 5'd0, 5'd1, 32'h55, 32'h99);
    push(cyc + 1, M_REGS, 1, 32'h100, 32'h4, 16'h0004, 3, 0, 1, 32'h55, 32'h0, 0, 16'd0);
    tick();

    // load to x5
    set_id(1'b1, 32'h104, 32'h8, 16'h0001, 5'd2, 5'd4, 5'd5, 32'h1111, 32'h2222);
    push(cyc + 1, M_REGS, 1, 32'h104, 32'h8, 16'h0001, 2, 4, 5, 32'h1111, 32'h2222, 0, 16'd0);
    tick();

    // load-use on rs2: hazard now, bubble next, then the held instruction
    set_id(1'b1, 32'h108, 32'hC, 16'h0004, 5'd6, 5'd5, 5'd7, 32'h3333, 32'h4444);
    push(cyc, M_HAZ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
    push(cyc + 1, M_BUB, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1'b0, 16'd1);
    tick();
    push(cyc + 1, M_REGS, 1, 32'h108, 32'hC, 16'h0004, 6, 5, 7, 32'h3333, 32'h4444, 0, 16'd1);
    tick();

    // load writing x0 never raises a hazard
    set_id(1'b1, 32'h10C, 32'h0, 16'h0001, 5'd0, 5'd0, 5'd0, 32'h77, 32'h88);
    push(cyc + 1, M_REGS, 1, 32'h10C, 32'h0, 16'h0001, 0, 0, 0, 32'h0, 32'h0, 0, 16'd1);
    tick();
    set_id(1'b1, 32'h110, 32'h0, 16'h0004, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0);
    push(cyc, M_HAZ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    push(cyc + 1, 11'h403, 1, 32'h110, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);
    tick();

    // writeback bypass at capture
    set_id(1'b1, 32'h114, 32'h0, 16'h0004, 5'd7, 5'd8, 5'd3, 32'h11, 32'h33);
    set_wb(1'b1, 5'd7, 32'h22);
    push(cyc, M_HAZ, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    push(cyc + 1, 11'h193, 1, 32'h114, 0, 0, 7, 0, 0, BYP ? 32'h22 : 32'h11, 32'h33, 0, 0);
    tick();

    // instruction that will be stalled with rs2=x9
    set_id(1'b1, 32'h118, 32'h10, 16'h0006, 5'd1, 5'd9, 5'd4, 32'hA, 32'hB);
    set_wb(1'b0, 5'd0, 32'h0);
    push(cyc + 1, M_ALL, 1, 32'h118, 32'h10, 16'h0006, 1, 9, 4, 32'hA, 32'hB, 0, 16'd1);
    tick();

    // three stall cycles; WB writes x9 in the second one
    stall = 1'b1;
    set_id(1'b1, 32'h200, 32'h20, 16'h0001, 5'd2, 5'd2, 5'd9, 32'hDEAD, 32'hDEAD);
    push(cyc + 1, M_REGS, 1, 32'h118, 32'h10, 16'h0006, 1, 9, 4, 32'hA, 32'hB, 0, 16'd1);
    tick();
    set_wb(1'b1, 5'd9, 32'hABCD);
    push(cyc + 1, M_REGS, 1, 32'h118, 32'h10, 16'h0006, 1, 9, 4, 32'hA,
         BYP ? 32'hABCD : 32'hB, 0, 16'd1);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    push(cyc + 1, M_REGS, 1, 32'h118, 32'h10, 16'h0006, 1, 9, 4, 32'hA,
         BYP ? 32'hABCD : 32'hB, 0, 16'd1);
    tick();

    // flush wins over stall and is not counted as a bubble
    flush = 1'b1;
    set_id(1'b1, 32'h300, 32'h0, 16'h0001, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0);
    set_wb(1'b1, 5'd0, 32'hFFFF);
    push(cyc + 1, M_BUB, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1'b0, 16'd1);
    tick();

    // writeback to x0 never bypasses
    flush = 1'b0; stall = 1'b0;
    set_id(1'b1, 32'h304, 32'h0, 16'h0000, 5'd3, 5'd0, 5'd1, 32'h66, 32'h77);
    push(cyc + 1, 11'h18B, 1, 32'h304, 0, 16'h0, 0, 0, 0, 32'h66, 32'h0, 0, 0);
    tick();

    // id_valid=0 propagates to ex_valid
    set_wb(1'b0, 5'd0, 32'h0);
    set_id(1'b0, 32'h308, 32'h0, 16'h0000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    push(cyc + 1, 11'h003, 0, 32'h308, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // asynchronous reset with an instruction in flight
    set_id(1'b1, 32'h400, 32'h4, 16'h0001, 5'd1, 5'd2, 5'd6, 32'h12, 32'h34);
    tick();
    #2;
    rst = 1'b0;
    push(cyc, M_ALL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
    tick();
    rst = 1'b1;
    drive_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    wait (drive_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      checks++;
      errors++;
      $display("FAIL timeout: expectation never checked");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

endmodule
